// File: rtl/fetch_stage.sv
// fetch_stage: RV32I PC, single-outstanding imem handshake and IF/ID register.
// Optional misaligned-redirect trap enabled by FETCH_MISALIGN_TRAP_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic [6:0]  opcode,
  output logic        fetch_fault
);
  typedef enum logic [1:0] {FETCH, HOLD, DROP, FAULT} state_t;
  localparam logic [31:0] NOP = 32'h0000_0013;
  state_t      state;
  logic [31:0] pc, addr_q, skid_pc, skid_instr, tgt, pc_inc;
  logic        fault_q, misalign;
  assign pc_inc = pc + 32'd4;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign tgt = redirect_pc;
  assign misalign = redirect & |redirect_pc[1:0];
`else
  assign tgt = redirect_pc & ~32'h3;
  assign misalign = 1'b0;
`endif
  assign fetch_fault = fault_q;
  // Request drops with rst itself so an in-flight fetch is abandoned immediately.
  assign imem_req = !rst && (state == FETCH || state == DROP);
  assign imem_addr = addr_q;
  assign opcode = if_id_instr[6:0];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      pc <= RESET_PC;
      addr_q <= RESET_PC;
      if_id_valid <= 1'b0;
      if_id_pc <= 32'h0;
      if_id_instr <= NOP;
      skid_pc <= 32'h0;
      skid_instr <= 32'h0;
      fault_q <= 1'b0;
    end else if (redirect) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP;
      skid_pc <= 32'h0;
      skid_instr <= 32'h0;
      pc <= tgt;
      if (misalign) fault_q <= 1'b1;
      if (state != FAULT) begin
        // An unanswered request must complete before the target can be issued.
        if ((state == FETCH || state == DROP) && !imem_ready) state <= DROP;
        else begin
          addr_q <= tgt;
          state <= (misalign || fault_q) ? FAULT : FETCH;
        end
      end
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready) begin
            pc <= pc_inc;
            if (stall) begin
              skid_pc <= addr_q;
              skid_instr <= imem_rdata;
              state <= HOLD;
            end else begin
              if_id_valid <= 1'b1;
              if_id_pc <= addr_q;
              if_id_instr <= imem_rdata;
              addr_q <= pc_inc;
            end
          end else if (!stall) begin
            if_id_valid <= 1'b0;
            if_id_instr <= NOP;
          end
        end
        HOLD: begin
          if (!stall) begin
            if_id_valid <= 1'b1;
            if_id_pc <= skid_pc;
            if_id_instr <= skid_instr;
            addr_q <= pc;
            state <= FETCH;
          end
        end
        DROP: begin
          if (imem_ready) begin
            addr_q <= pc;
            state <= fault_q ? FAULT : FETCH;
          end
        end
        default: begin
          if_id_valid <= 1'b0;
          if_id_instr <= NOP;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst, stall, redirect, imem_ready;
  logic [31:0] redirect_pc;
  logic        imem_req, if_id_valid, fetch_fault;
  logic [31:0] imem_addr, imem_rdata, if_id_pc, if_id_instr;
  logic [6:0]  opcode;
  int n_cmp = 0;
  int n_bad = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
    .opcode(opcode), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a == 32'h8) ? 32'h0020_8093 : {a[23:0], 8'h33};
  endfunction

  assign imem_rdata = word(imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; imem_ready = 1'b1;
    tick(); tick();
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
    n_cmp++; if (if_id_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", if_id_valid); end
    n_cmp++; if (if_id_instr !== 32'h13) begin n_bad++; $display("FAIL rst_instr: got %h want 00000013", if_id_instr); end
    n_cmp++; if (if_id_pc !== 32'h0) begin n_bad++; $display("FAIL rst_pc: got %h want 0", if_id_pc); end
    n_cmp++; if (fetch_fault !== 1'b0) begin n_bad++; $display("FAIL rst_fault: got %b want 0", fetch_fault); end
    rst = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_bad++; $display("FAIL first_req: got %b/%h want 1/0", imem_req, imem_addr); end
  endtask

  task automatic test_stream();
    tick();
    n_cmp++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0 || if_id_instr !== 32'h33) begin n_bad++; $display("FAIL stream0: got %b/%h/%h want 1/0/33", if_id_valid, if_id_pc, if_id_instr); end
    n_cmp++; if (imem_addr !== 32'h4) begin n_bad++; $display("FAIL stream_addr4: got %h want 4", imem_addr); end
    tick();
    n_cmp++; if (if_id_pc !== 32'h4 || imem_addr !== 32'h8) begin n_bad++; $display("FAIL stream1: got %h/%h want 4/8", if_id_pc, imem_addr); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (imem_req !== 1'b0 || if_id_pc !== 32'h4 || if_id_valid !== 1'b1) begin n_bad++; $display("FAIL stall_hold%0d: got req %b pc %h v %b want 0/4/1", i, imem_req, if_id_pc, if_id_valid); end
    end
    stall = 1'b0;
    tick();
    n_cmp++; if (if_id_pc !== 32'h8 || if_id_instr !== 32'h0020_8093 || if_id_valid !== 1'b1) begin n_bad++; $display("FAIL stall_release: got %h/%h want 8/00208093", if_id_pc, if_id_instr); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin n_bad++; $display("FAIL stall_next: got %b/%h want 1/c", imem_req, imem_addr); end
  endtask

  task automatic test_wait();
    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h13 || opcode !== 7'b0010011) begin n_bad++; $display("FAIL bubble%0d: got %b/%h/%b want 0/13/0010011", i, if_id_valid, if_id_instr, opcode); end
      n_cmp++; if (imem_addr !== 32'hC) begin n_bad++; $display("FAIL wait_addr%0d: got %h want c", i, imem_addr); end
    end
    imem_ready = 1'b1;
    tick();
    n_cmp++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'hC || imem_addr !== 32'h10) begin n_bad++; $display("FAIL wait_resume: got %b/%h/%h want 1/c/10", if_id_valid, if_id_pc, imem_addr); end
  endtask

  task automatic test_redirect_drop();
    for (int i = 0; i < 4; i++) tick();
    n_cmp++; if (imem_addr !== 32'h20) begin n_bad++; $display("FAIL drop_setup: got %h want 20", imem_addr); end
    imem_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h20 || if_id_valid !== 1'b0) begin n_bad++; $display("FAIL drop_enter: got %b/%h/%b want 1/20/0", imem_req, imem_addr, if_id_valid); end
    tick();
    n_cmp++; if (imem_addr !== 32'h20) begin n_bad++; $display("FAIL drop_stable: got %h want 20", imem_addr); end
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0; imem_ready = 1'b1;
    n_cmp++; if (imem_addr !== 32'h20) begin n_bad++; $display("FAIL drop_second: got %h want 20", imem_addr); end
    tick();
    n_cmp++; if (imem_addr !== 32'h200 || if_id_valid !== 1'b0 || if_id_instr !== 32'h13) begin n_bad++; $display("FAIL drop_done: got %h/%b/%h want 200/0/13", imem_addr, if_id_valid, if_id_instr); end
    tick();
    n_cmp++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h200 || imem_addr !== 32'h204) begin n_bad++; $display("FAIL drop_target: got %b/%h/%h want 1/200/204", if_id_valid, if_id_pc, imem_addr); end
  endtask

  task automatic test_redirect_fast();
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    n_cmp++; if (if_id_valid !== 1'b0 || imem_addr !== 32'h100) begin n_bad++; $display("FAIL fast_bubble: got %b/%h want 0/100", if_id_valid, imem_addr); end
    tick();
    n_cmp++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h100 || imem_addr !== 32'h104) begin n_bad++; $display("FAIL fast_target: got %b/%h/%h want 1/100/104", if_id_valid, if_id_pc, imem_addr); end
  endtask

  task automatic test_redirect_stall();
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect = 1'b0;
    n_cmp++; if (if_id_valid !== 1'b0 || imem_addr !== 32'h300 || imem_req !== 1'b1) begin n_bad++; $display("FAIL rs_flush: got %b/%h/%b want 0/300/1", if_id_valid, imem_addr, imem_req); end
    tick();
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rs_hold: got %b want 0", imem_req); end
    redirect = 1'b1; redirect_pc = 32'h400;
    tick();
    redirect = 1'b0; stall = 1'b0;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h400 || if_id_valid !== 1'b0) begin n_bad++; $display("FAIL rs_hold_redirect: got %b/%h/%b want 1/400/0", imem_req, imem_addr, if_id_valid); end
    tick();
    n_cmp++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h400) begin n_bad++; $display("FAIL rs_target: got %b/%h want 1/400", if_id_valid, if_id_pc); end
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    tick();
    n_cmp++; if (if_id_pc !== 32'hFFFF_FFFC || imem_addr !== 32'h0) begin n_bad++; $display("FAIL wrap: got %h/%h want fffffffc/0", if_id_pc, imem_addr); end
  endtask

  task automatic test_rst_mid();
    imem_ready = 1'b0;
    tick();
    n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL mid_pending: got %b want 1", imem_req); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (imem_req !== 1'b0 || if_id_valid !== 1'b0 || imem_addr !== 32'h0) begin n_bad++; $display("FAIL mid_async: got %b/%b/%h want 0/0/0", imem_req, if_id_valid, imem_addr); end
    tick();
    rst = 1'b0; imem_ready = 1'b1;
    #1;
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_bad++; $display("FAIL mid_restart: got %b/%h want 1/0", imem_req, imem_addr); end
  endtask

  task automatic test_misalign();
    redirect = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    n_cmp++; if (fetch_fault !== 1'b1 || imem_req !== 1'b0 || if_id_valid !== 1'b0) begin n_bad++; $display("FAIL trap: got %b/%b/%b want 1/0/0", fetch_fault, imem_req, if_id_valid); end
    tick(); tick();
    n_cmp++; if (fetch_fault !== 1'b1 || imem_req !== 1'b0 || if_id_valid !== 1'b0) begin n_bad++; $display("FAIL trap_sticky: got %b/%b/%b want 1/0/0", fetch_fault, imem_req, if_id_valid); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++; if (fetch_fault !== 1'b0) begin n_bad++; $display("FAIL trap_clear: got %b want 0", fetch_fault); end
`else
    n_cmp++; if (imem_addr !== 32'h100 || fetch_fault !== 1'b0 || imem_req !== 1'b1) begin n_bad++; $display("FAIL align_force: got %h/%b/%b want 100/0/1", imem_addr, fetch_fault, imem_req); end
    tick();
    n_cmp++; if (if_id_pc !== 32'h100 || if_id_valid !== 1'b1) begin n_bad++; $display("FAIL align_target: got %h/%b want 100/1", if_id_pc, if_id_valid); end
`endif
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_wait();
    test_redirect_drop();
    test_redirect_fast();
    test_redirect_stall();
    test_wrap();
    test_rst_mid();
    test_misalign();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
